// File: rtl/tic_tac_toe_pkg.sv
// Shared constants for the tic-tac-toe core and its automated O-side player:
// cell/win codes, the eight winning lines, fallback move order and FSM states.
package tic_tac_toe_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_O     = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // Cell numbers are 1..9, row-major from the top-left corner.
    localparam logic [3:0] LINES [0:7][0:2] = '{
        '{4'd1, 4'd2, 4'd3},
        '{4'd4, 4'd5, 4'd6},
        '{4'd7, 4'd8, 4'd9},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd3, 4'd6, 4'd9},
        '{4'd1, 4'd5, 4'd9},
        '{4'd3, 4'd5, 4'd7}
    };

    // Centre, then corners (slots 1..4), then sides.
    localparam logic [3:0] FALLBACK_ORDER [0:8] = '{
        4'd5, 4'd1, 4'd3, 4'd7, 4'd9, 4'd2, 4'd4, 4'd6, 4'd8
    };

    localparam logic [3:0] CORNERS [0:3] = '{4'd1, 4'd3, 4'd7, 4'd9};

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_TURN = 3'd1;
    localparam logic [2:0] ST_THINK     = 3'd2;
    localparam logic [2:0] ST_SCAN      = 3'd3;
    localparam logic [2:0] ST_PLAY      = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    localparam logic [4:0] SCAN_FALLBACK = 5'd16;

    // Number of cells in an 18-bit packed board {pos9..pos1} holding exactly mark.
    function automatic logic [3:0] count_mark(input logic [17:0] board, input logic [1:0] mark);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 9; i++) begin
            if (board[2*i +: 2] == mark) n = n + 4'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Combinational evaluation of one board line: hit when two cells hold the
// target mark and the third is empty; slot gives the empty cell's position.
module ttt_line_eval
    import tic_tac_toe_pkg::*;
(
    input  logic [1:0] c0,
    input  logic [1:0] c1,
    input  logic [1:0] c2,
    input  logic [1:0] mark,
    output logic       hit,
    output logic [1:0] slot
);

    logic m0, m1, m2;
    logic e0, e1, e2;

    always_comb begin
        m0 = (c0 == mark);
        m1 = (c1 == mark);
        m2 = (c2 == mark);
        e0 = (c0 == CELL_EMPTY);
        e1 = (c1 == CELL_EMPTY);
        e2 = (c2 == CELL_EMPTY);
        hit = (m0 & m1 & e2) | (m0 & e1 & m2) | (e0 & m1 & m2);
        if (e0)      slot = 2'd0;
        else if (e1) slot = 2'd1;
        else         slot = 2'd2;
    end

endmodule

// File: rtl/tic_tac_toe_auto_player.sv
// Automated O-side opponent: on O's turn it scans for win, block, then
// centre/corner/side and strobes the move. Option macro: AUTO_PLAYER_LFSR_EN.
module tic_tac_toe_auto_player
    import tic_tac_toe_pkg::*;
#(
    parameter int PLAY_CYCLES = 5,
    parameter int GAP_CYCLES  = 5,
    parameter int THINK_MIN   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] win,
    output logic       play,
    output logic [3:0] pos_play,
    output logic       busy,
    output logic [2:0] move_cnt
);

    localparam logic [15:0] THINK_LAST = 16'(THINK_MIN);
    localparam logic [15:0] PLAY_LAST  = 16'(PLAY_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic [4:0]  s;

    logic [1:0]  cells [0:8];
    logic [17:0] board_vec;
    logic [3:0]  nx, no;
    logic        o_turn;

    assign cells[0] = pos1;
    assign cells[1] = pos2;
    assign cells[2] = pos3;
    assign cells[3] = pos4;
    assign cells[4] = pos5;
    assign cells[5] = pos6;
    assign cells[6] = pos7;
    assign cells[7] = pos8;
    assign cells[8] = pos9;
    assign board_vec = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    // Code 11 matches neither mark, so it is excluded from both counts.
    assign nx     = count_mark(board_vec, CELL_X);
    assign no     = count_mark(board_vec, CELL_O);
    assign o_turn = (win == WIN_NONE) && (nx == no + 4'd1);

    assign busy = (state != ST_IDLE) && (state != ST_WAIT_TURN);

    // Line mux: s[2:0] selects the line, s[3] selects win (O) or block (X) pass.
    logic [2:0] line_idx;
    logic [1:0] lc0, lc1, lc2, line_mark;
    logic       line_hit;
    logic [1:0] line_slot;
    logic [3:0] line_cell;

    always_comb begin
        line_idx  = s[2:0];
        lc0       = cells[LINES[line_idx][0] - 4'd1];
        lc1       = cells[LINES[line_idx][1] - 4'd1];
        lc2       = cells[LINES[line_idx][2] - 4'd1];
        line_mark = s[3] ? CELL_X : CELL_O;
    end

    ttt_line_eval u_line_eval (
        .c0   (lc0),
        .c1   (lc1),
        .c2   (lc2),
        .mark (line_mark),
        .hit  (line_hit),
        .slot (line_slot)
    );

    always_comb begin
        case (line_slot)
            2'd0:    line_cell = LINES[line_idx][0];
            2'd1:    line_cell = LINES[line_idx][1];
            default: line_cell = LINES[line_idx][2];
        endcase
    end

`ifdef AUTO_PLAYER_LFSR_EN
    logic [7:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
`endif

    logic       fb_found;
    logic [3:0] fb_cell;
    logic [3:0] cand;

    always_comb begin
        fb_found = 1'b0;
        fb_cell  = 4'd0;
        cand     = 4'd0;
        for (int k = 0; k < 9; k++) begin
            cand = FALLBACK_ORDER[k];
`ifdef AUTO_PLAYER_LFSR_EN
            // Corner slots are rotated to start at the LFSR-chosen corner.
            if (k >= 1 && k <= 4) cand = CORNERS[2'(lfsr[1:0] + 2'(k - 1))];
`endif
            if (!fb_found && cells[cand - 4'd1] == CELL_EMPTY) begin
                fb_found = 1'b1;
                fb_cell  = cand;
            end
        end
    end

    logic       move_go;
    logic [3:0] move_cell;

    always_comb begin
        if (s < SCAN_FALLBACK) begin
            move_go   = line_hit;
            move_cell = line_cell;
        end else begin
            move_go   = fb_found;
            move_cell = fb_cell;
        end
    end

    // Handshake: the core samples play as a level; pos_play is valid and held
    // for every clock play is high, and both drop together before the next move.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= 16'd0;
            s        <= 5'd0;
            play     <= 1'b0;
            pos_play <= 4'd0;
            move_cnt <= 3'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_WAIT_TURN;
                end
                ST_WAIT_TURN: begin
                    if (!en) begin
                        state <= ST_IDLE;
                    end else if (o_turn) begin
                        state <= ST_THINK;
                        cnt   <= 16'd0;
                    end
                end
                ST_THINK: begin
                    if (!o_turn) begin
                        state <= ST_WAIT_TURN;
                    end else if (cnt == THINK_LAST) begin
                        state <= ST_SCAN;
                        s     <= 5'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_SCAN: begin
                    if (move_go) begin
                        state    <= ST_PLAY;
                        cnt      <= 16'd0;
                        play     <= 1'b1;
                        pos_play <= move_cell;
                        if (move_cnt != 3'd5) move_cnt <= move_cnt + 3'd1;
                    end else if (s == SCAN_FALLBACK) begin
                        // Full board: nothing to play, cool down and re-arm.
                        state <= ST_GAP;
                        cnt   <= 16'd0;
                    end else begin
                        s <= s + 5'd1;
                    end
                end
                ST_PLAY: begin
                    if (cnt == PLAY_LAST) begin
                        state    <= ST_GAP;
                        cnt      <= 16'd0;
                        play     <= 1'b0;
                        pos_play <= 4'd0;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) state <= ST_WAIT_TURN;
                    else                 cnt   <= cnt + 16'd1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tic_tac_toe_auto_player.sv
// Directed bench for tic_tac_toe_auto_player: a vector table of boards with
// hand-computed moves, plus sequences for retry, saturation, reset and game end.
module tb_tic_tac_toe_auto_player;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] board [0:8];
    logic [1:0] win = 2'b00;
    logic       play;
    logic [3:0] pos_play;
    logic       busy;
    logic [2:0] move_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tic_tac_toe_auto_player dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pos1     (board[0]),
        .pos2     (board[1]),
        .pos3     (board[2]),
        .pos4     (board[3]),
        .pos5     (board[4]),
        .pos6     (board[5]),
        .pos7     (board[6]),
        .pos8     (board[7]),
        .pos9     (board[8]),
        .win      (win),
        .play     (play),
        .pos_play (pos_play),
        .busy     (busy),
        .move_cnt (move_cnt)
    );

    typedef struct {
        string      name;
        string      cells;
        logic [1:0] win;
        bit         exp_move;
        logic [3:0] exp_pos;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cells string: char i is cell i+1; 'X', 'O' or anything else for empty.
    task automatic set_board(input string cells);
        for (int i = 0; i < 9; i++) begin
            byte c;
            c = cells.getc(i);
            if (c == "X")      board[i] = 2'b01;
            else if (c == "O") board[i] = 2'b10;
            else               board[i] = 2'b00;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        win = 2'b00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_play(input int budget, output bit seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (play) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // Called right after play is sampled high: measures the strobe and checks the GAP clock.
    task automatic check_strobe(input string name, input logic [3:0] exp_pos);
        int hi;
        bit stable;
        hi = 1;
        stable = 1'b1;
        check({name, "_pos"}, pos_play, exp_pos);
        check({name, "_busy"}, busy, 1);
        for (int n = 0; n < 20; n++) begin
            tick();
            if (!play) break;
            hi++;
            if (pos_play !== exp_pos) stable = 1'b0;
        end
        check({name, "_play_len"}, hi, 5);
        check({name, "_pos_stable"}, stable, 1);
        check({name, "_gap_pos"}, pos_play, 0);
    endtask

    initial begin
        bit seen;
        int play_hi, busy_hi;

        for (int i = 0; i < 9; i++) board[i] = 2'b00;

        vecs[0] = '{"centre_taken", "....X....", 2'b00, 1'b1, 4'd1};
        vecs[1] = '{"block_row",    "XX..O....", 2'b00, 1'b1, 4'd3};
        vecs[2] = '{"win_over_blk", "OO.XX...X", 2'b00, 1'b1, 4'd3};
        vecs[3] = '{"take_centre",  "X........", 2'b00, 1'b1, 4'd5};
        vecs[4] = '{"corner_fb",    "X...O...X", 2'b00, 1'b1, 4'd3};
        vecs[5] = '{"block_col",    "O.X..X...", 2'b00, 1'b1, 4'd9};
        vecs[6] = '{"x_turn",       "O...X....", 2'b00, 1'b0, 4'd0};
        vecs[7] = '{"empty_board",  ".........", 2'b00, 1'b0, 4'd0};
        vecs[8] = '{"x_won",        "XXX.OO...", 2'b01, 1'b0, 4'd0};

        for (int v = 0; v < NV; v++) begin
            do_reset();
            check({vecs[v].name, "_rst_play"}, play, 0);
            check({vecs[v].name, "_rst_pos"}, pos_play, 0);
            check({vecs[v].name, "_rst_busy"}, busy, 0);
            check({vecs[v].name, "_rst_cnt"}, move_cnt, 0);
            set_board(vecs[v].cells);
            win = vecs[v].win;
            en  = 1'b1;
            if (vecs[v].exp_move) begin
                wait_play(60, seen);
                check({vecs[v].name, "_seen"}, seen, 1);
                if (seen) begin
                    check({vecs[v].name, "_cnt"}, move_cnt, 1);
                    check_strobe(vecs[v].name, vecs[v].exp_pos);
                end
            end else begin
                play_hi = 0;
                busy_hi = 0;
                for (int n = 0; n < 100; n++) begin
                    tick();
                    if (play) play_hi++;
                    if (busy) busy_hi++;
                end
                check({vecs[v].name, "_no_play"}, play_hi, 0);
                check({vecs[v].name, "_no_busy"}, busy_hi, 0);
            end
        end

        // Core ignores the move: the same move repeats and move_cnt saturates at 5.
        do_reset();
        set_board("....X....");
        en = 1'b1;
        for (int m = 1; m <= 6; m++) begin
            wait_play(60, seen);
            check($sformatf("retry%0d_seen", m), seen, 1);
            if (!seen) break;
            check($sformatf("retry%0d_cnt", m), move_cnt, (m > 5) ? 5 : m);
            check_strobe($sformatf("retry%0d", m), 4'd1);
        end

        // Reset asserted for the second play-high clock drops everything on that edge.
        do_reset();
        set_board("XX..O....");
        en = 1'b1;
        wait_play(60, seen);
        check("midrst_seen", seen, 1);
        rst = 1'b1;
        tick();
        check("midrst_play", play, 0);
        check("midrst_pos", pos_play, 0);
        check("midrst_cnt", move_cnt, 0);
        check("midrst_busy", busy, 0);
        rst = 1'b0;

        // Enable low: no move even though it is O's turn.
        do_reset();
        set_board("....X....");
        play_hi = 0;
        busy_hi = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (play) play_hi++;
            if (busy) busy_hi++;
        end
        check("en_low_play", play_hi, 0);
        check("en_low_busy", busy_hi, 0);

        // Game ends during PLAY: strobe completes, then the block parks.
        en = 1'b1;
        wait_play(60, seen);
        check("end_seen", seen, 1);
        win = 2'b10;
        check_strobe("end", 4'd1);
        play_hi = 0;
        for (int n = 0; n < 60; n++) begin
            tick();
            if (play) play_hi++;
        end
        check("end_no_replay", play_hi, 0);
        check("end_parked_busy", busy, 0);
        check("end_cnt", move_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
